window_3x3_buffer: RTL and testbench
====================================

// Module: window_3x3_buffer
// PURPOSE
//  Streaming 3x3 neighbourhood generator between the grayscale stage and the Sobel kernel.
//  Accepts one 8-bit luma pixel per valid cycle in raster order.
//  Stores the two previous image rows in line FIFOs.
//  Emits a registered 3x3 window for every interior pixel position.
//  No back-pressure: the consumer must accept every window on the cycle it is presented.
// PARAMETERS
//  P_PIXEL_DEPTH   8    bits per grayscale pixel
//  P_IMAGE_WIDTH   640  pixels per row (>=3)
//  P_IMAGE_HEIGHT  480  rows per frame (>=3)
// PORTS
//  I_CLK           in   1    clock, all logic on rising edge
//  I_RESET         in   1    synchronous, active-high reset
//  I_VALID         in   1    I_PIXEL valid this cycle; driven one cycle late to align with grayscale output register
//  I_FRAME_START   in   1    qualified by I_VALID: this pixel is (row0,col0)
//  I_PIXEL         in   8    grayscale pixel
//  O_WINDOW        out  72   {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 in [71:64]; row 0 oldest, col 0 leftmost
//  O_WINDOW_VALID  out  1    O_WINDOW holds a new window this cycle (1-cycle pulse per window)
//  O_FRAME_DONE    out  1    1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  Reset: O_WINDOW=0, O_WINDOW_VALID=0, O_FRAME_DONE=0, row/col counters=0, state=S_IDLE.
//   Line FIFO contents are not cleared; they are never read before being rewritten.
//  Accept: a pixel is consumed only when I_VALID=1. I_VALID=0 freezes all state and O_WINDOW.
//   O_WINDOW_VALID and O_FRAME_DONE deassert during such cycles.
//  Per accepted pixel at (r,c):
//   - fifo1 read at c gives (r-1,c); fifo2 read at c gives (r-2,c).
//   - fifo2[c]<=fifo1[c] and fifo1[c]<=I_PIXEL in the same cycle (read-before-write).
//   - Window column registers shift left; new right column = {fifo2 out, fifo1 out, I_PIXEL}.
//  Counters: col 0..W-1, $clog2(W) bits; row 0..H-1, $clog2(H) bits.
//   - col wraps to 0 with row+1.
//   - At (H-1,W-1) both counters clear; O_FRAME_DONE=1 next cycle.
//  Output: if the accepted pixel has r>=2 and c>=2, then the next cycle O_WINDOW_VALID=1.
//   O_WINDOW is then centred on (r-1,c-1). Latency is 1 cycle from accept.
//   Border pixels produce no window; output count per frame = (H-2)*(W-2).
//   Columns c=0,1 of each row only refill the column registers (no window across row wrap).
//  FSM (2-bit):
//   - S_IDLE -> S_FILL on any accepted pixel.
//   - S_FILL (rows 0..1) -> S_ACTIVE on accept at (1,W-1).
//   - S_ACTIVE -> S_IDLE on accept at (H-1,W-1).
//   - O_WINDOW_VALID is only possible in S_ACTIVE.
//  I_FRAME_START with I_VALID, in any state: that pixel is forced to (0,0); state->S_FILL.
//   Any partial frame is abandoned with no O_FRAME_DONE.
//   I_FRAME_START without I_VALID is ignored.
//  Reset mid-frame: the next accepted pixel is treated as (0,0). No stale window is emitted.
//  Simultaneous last pixel + window: O_WINDOW_VALID and O_FRAME_DONE both pulse in the same cycle.
// STRUCTURE
//  Shared package edge_pkg: P_PIXEL_DEPTH, window width (9*P_PIXEL_DEPTH), FSM state encodings S_IDLE/S_FILL/S_ACTIVE.
//  Sub-module line_fifo (params P_DEPTH=P_IMAGE_WIDTH, P_WIDTH=8):
//   - one synchronous-addressed RAM with combinational read of addr and write of the same addr on the same edge.
//   - Instantiated twice.
//  Top holds counters, FSM, 3x3 register array, output registers.
// TESTING (bench params W=4, H=4; pixel value = {row[3:0],col[3:0]})
//  1 Continuous frame, I_VALID=1 every cycle, I_FRAME_START on first pixel
//     -> exactly 4 windows, in order centred (1,1),(1,2),(2,1),(2,2).
//     First window = {00,01,02,10,11,12,20,21,22}, arriving 1 cycle after pixel 0x22 is accepted.
//     O_FRAME_DONE pulses once, coincident with the 4th window.
//  2 Same frame with I_VALID toggling 1,0,1,0
//     -> identical window sequence and values; O_WINDOW stable while I_VALID=0.
//  3 Reset asserted after pixel 0x21, then a new frame of value 0x80+idx
//     -> no window from old data; first window p00=0x80.
//  4 I_FRAME_START re-asserted at pixel (2,1)
//     -> no O_FRAME_DONE for the aborted frame; new frame yields 4 correct windows.
//  5 Two back-to-back frames, no idle gap
//     -> 8 windows, 2 O_FRAME_DONE pulses, 2nd frame's first window contains no 1st-frame pixels.
//  6 Reset check: hold I_RESET 3 cycles
//     -> O_WINDOW=0, O_WINDOW_VALID=0, O_FRAME_DONE=0 from the first edge.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the grayscale-to-Sobel edge pipeline: pixel/window
// widths and the window generator's FSM encodings.
package edge_pkg;

    localparam int P_PIXEL_DEPTH  = 8;
    localparam int P_WINDOW_WIDTH = 9 * P_PIXEL_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/line_fifo.sv
// One image row of storage: combinational read at i_addr and a write to the
// same address on the clock edge, so a read-modify-write happens in one cycle.
module line_fifo #(
    parameter int P_DEPTH = 640,
    parameter int P_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(P_DEPTH)-1:0] i_addr,
    input  logic [P_WIDTH-1:0]         i_wr_data,
    output logic [P_WIDTH-1:0]         o_rd_data
);

    // Contents are never cleared; every location is rewritten before use.
    logic [P_WIDTH-1:0] r_mem [P_DEPTH];

    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/window_3x3_buffer.sv
// Streaming 3x3 neighbourhood generator: two line FIFOs plus a 3x3 column
// shift array, emitting one registered window per interior pixel.
module window_3x3_buffer #(
    parameter int P_PIXEL_DEPTH  = 8,
    parameter int P_IMAGE_WIDTH  = 640,
    parameter int P_IMAGE_HEIGHT = 480
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_VALID,
    input  logic                         I_FRAME_START,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    output logic [9*P_PIXEL_DEPTH-1:0]   O_WINDOW,
    output logic                         O_WINDOW_VALID,
    output logic                         O_FRAME_DONE,
    output logic [1:0]                   O_DBG_STATE
);

    import edge_pkg::*;

    localparam int L_COL_W = $clog2(P_IMAGE_WIDTH);
    localparam int L_ROW_W = $clog2(P_IMAGE_HEIGHT);
    localparam logic [L_COL_W-1:0] L_LAST_COL = L_COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [L_ROW_W-1:0] L_LAST_ROW = L_ROW_W'(P_IMAGE_HEIGHT - 1);
    localparam logic [L_COL_W-1:0] L_COL_TWO  = L_COL_W'(2);
    localparam logic [L_ROW_W-1:0] L_ROW_ONE  = L_ROW_W'(1);
    localparam logic [L_ROW_W-1:0] L_ROW_TWO  = L_ROW_W'(2);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [L_ROW_W-1:0]         r_row;
    logic [L_COL_W-1:0]         r_col;
    logic [L_ROW_W-1:0]         w_row;
    logic [L_COL_W-1:0]         w_col;
    logic                       w_accept;
    logic                       w_last_col;
    logic                       w_last_row;
    logic                       w_emit;
    logic                       w_done;
    logic [P_PIXEL_DEPTH-1:0]   w_fifo1_q;
    logic [P_PIXEL_DEPTH-1:0]   w_fifo2_q;
    logic [P_PIXEL_DEPTH-1:0]   r_win [3][3];
    logic                       r_window_valid;
    logic                       r_frame_done;

    // A qualified frame start overrides the counters: this pixel is (0,0).
    always_comb begin
        w_accept   = I_VALID;
        w_row      = I_FRAME_START ? '0 : r_row;
        w_col      = I_FRAME_START ? '0 : r_col;
        w_last_col = (w_col == L_LAST_COL);
        w_last_row = (w_row == L_LAST_ROW);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            if (I_FRAME_START) begin
                w_next_state = S_FILL;
            end else begin
                case (r_state)
                    S_IDLE:   w_next_state = S_FILL;
                    S_FILL:   if (w_row == L_ROW_ONE && w_last_col) w_next_state = S_ACTIVE;
                    S_ACTIVE: if (w_last_row && w_last_col) w_next_state = S_IDLE;
                    default:  w_next_state = S_IDLE;
                endcase
            end
        end
    end

    // Windows need two full rows above and two columns to the left.
    always_comb begin
        w_emit = w_accept && (r_state == S_ACTIVE) &&
                 (w_row >= L_ROW_TWO) && (w_col >= L_COL_TWO);
        w_done = w_accept && w_last_row && w_last_col;
    end

    line_fifo #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (P_PIXEL_DEPTH)
    ) u_fifo1 (
        .i_clk     (I_CLK),
        .i_wr_en   (w_accept),
        .i_addr    (w_col),
        .i_wr_data (I_PIXEL),
        .o_rd_data (w_fifo1_q)
    );

    line_fifo #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (P_PIXEL_DEPTH)
    ) u_fifo2 (
        .i_clk     (I_CLK),
        .i_wr_en   (w_accept),
        .i_addr    (w_col),
        .i_wr_data (w_fifo1_q),
        .o_rd_data (w_fifo2_q)
    );

    // r_win[row][col]: row 0 oldest, col 2 newest.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_fifo2_q;
            r_win[1][2] <= w_fifo1_q;
            r_win[2][2] <= I_PIXEL;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= w_emit;
            r_frame_done   <= w_done;
        end
    end

    always_comb begin
        O_WINDOW = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                O_WINDOW[(8 - (3 * i + j)) * P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = r_win[i][j];
            end
        end
    end

    assign O_WINDOW_VALID = r_window_valid;
    assign O_FRAME_DONE   = r_frame_done;
    assign O_DBG_STATE    = r_state;

endmodule

// File: tb/tb_window_3x3_buffer.sv
// Directed bench for window_3x3_buffer on a 4x4 image: a vector table for the
// plain frame plus hand-written sequences for gaps, resets and frame aborts.
module tb_window_3x3_buffer;

    import edge_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_VALID;
    logic        I_FRAME_START;
    logic [7:0]  I_PIXEL;
    logic [71:0] O_WINDOW;
    logic        O_WINDOW_VALID;
    logic        O_FRAME_DONE;
    logic [1:0]  O_DBG_STATE;

    int n_checks = 0;
    int n_errors = 0;
    int n_win    = 0;
    int n_done   = 0;
    logic [71:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic        fs;
        logic [7:0]  pix;
        logic        exp_v;
        logic [71:0] exp_win;
        logic        exp_done;
    } vec_t;

    vec_t tbl[W*H];

    window_3x3_buffer #(
        .P_PIXEL_DEPTH  (8),
        .P_IMAGE_WIDTH  (W),
        .P_IMAGE_HEIGHT (H)
    ) dut (
        .I_CLK          (I_CLK),
        .I_RESET        (I_RESET),
        .I_VALID        (I_VALID),
        .I_FRAME_START  (I_FRAME_START),
        .I_PIXEL        (I_PIXEL),
        .O_WINDOW       (O_WINDOW),
        .O_WINDOW_VALID (O_WINDOW_VALID),
        .O_FRAME_DONE   (O_FRAME_DONE),
        .O_DBG_STATE    (O_DBG_STATE)
    );

    always #5 I_CLK = ~I_CLK;

    // mode 0: {row,col} nibbles; mode 1: 0x80 + raster index
    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        if (mode == 0) return 8'((r << 4) | c);
        return 8'(8'h80 + r * W + c);
    endfunction

    function automatic logic [71:0] model_win(input int mode, input int cr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w = {w[63:0], pix(mode, cr - 1 + i, cc - 1 + j)};
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic fs, input logic [7:0] p,
                        input logic ev, input logic [71:0] ew, input logic ed);
        I_VALID       = v;
        I_FRAME_START = fs;
        I_PIXEL       = p;
        if (ev) exp_q.push_back(ew);
        @(posedge I_CLK);
        #1;
        check("window_valid", 72'(O_WINDOW_VALID), 72'(ev));
        check("frame_done", 72'(O_FRAME_DONE), 72'(ed));
        if (O_WINDOW_VALID === 1'b1) begin
            n_win++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_window: got %h expected no window", O_WINDOW);
            end else begin
                check("window", O_WINDOW, exp_q.pop_front());
            end
        end
        if (O_FRAME_DONE === 1'b1) n_done++;
    endtask

    task automatic do_reset(input int cycles);
        I_RESET       = 1'b1;
        I_VALID       = 1'b0;
        I_FRAME_START = 1'b0;
        I_PIXEL       = '0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge I_CLK);
            #1;
            check("reset_window", O_WINDOW, '0);
            check("reset_valid", 72'(O_WINDOW_VALID), '0);
            check("reset_done", 72'(O_FRAME_DONE), '0);
            check("reset_state", 72'(O_DBG_STATE), 72'(S_IDLE));
        end
        I_RESET = 1'b0;
    endtask

    task automatic run_frame(input int mode, input logic fs_first, input logic toggle, input int n_pix);
        for (int idx = 0; idx < n_pix; idx++) begin
            int r;
            int c;
            logic ev;
            r  = idx / W;
            c  = idx % W;
            ev = (r >= 2) && (c >= 2);
            step(1'b1, fs_first && (idx == 0), pix(mode, r, c), ev,
                 model_win(mode, r - 1, c - 1), idx == W * H - 1);
            if (toggle) begin
                step(1'b0, 1'b0, 8'hee, 1'b0, '0, 1'b0);
                if (ev) check("window_hold", O_WINDOW, model_win(mode, r - 1, c - 1));
            end
        end
    endtask

    initial begin
        I_RESET       = 1'b1;
        I_VALID       = 1'b0;
        I_FRAME_START = 1'b0;
        I_PIXEL       = '0;

        // Reset held three cycles, outputs clear from the first edge
        do_reset(3);

        // Continuous frame from the vector table
        for (int i = 0; i < W * H; i++) begin
            tbl[i] = '{valid: 1'b1, fs: (i == 0), pix: pix(0, i / W, i % W),
                       exp_v: 1'b0, exp_win: '0, exp_done: 1'b0};
        end
        tbl[10].exp_v   = 1'b1;
        tbl[10].exp_win = 72'h00_01_02_10_11_12_20_21_22;
        tbl[11].exp_v   = 1'b1;
        tbl[11].exp_win = 72'h01_02_03_11_12_13_21_22_23;
        tbl[14].exp_v   = 1'b1;
        tbl[14].exp_win = 72'h10_11_12_20_21_22_30_31_32;
        tbl[15].exp_v   = 1'b1;
        tbl[15].exp_win = 72'h11_12_13_21_22_23_31_32_33;
        tbl[15].exp_done = 1'b1;
        n_win  = 0;
        n_done = 0;
        for (int i = 0; i < W * H; i++) begin
            step(tbl[i].valid, tbl[i].fs, tbl[i].pix, tbl[i].exp_v, tbl[i].exp_win, tbl[i].exp_done);
        end
        check("t1_windows", 72'(n_win), 72'(4));
        check("t1_done", 72'(n_done), 72'(1));
        check("t1_state_idle", 72'(O_DBG_STATE), 72'(S_IDLE));

        // Same frame with I_VALID toggling
        n_win  = 0;
        n_done = 0;
        run_frame(0, 1'b1, 1'b1, W * H);
        check("t2_windows", 72'(n_win), 72'(4));
        check("t2_done", 72'(n_done), 72'(1));

        // Reset after pixel 0x21, new frame without a frame start
        run_frame(0, 1'b1, 1'b0, 10);
        do_reset(1);
        n_win  = 0;
        n_done = 0;
        run_frame(1, 1'b0, 1'b0, W * H);
        check("t3_windows", 72'(n_win), 72'(4));
        check("t3_done", 72'(n_done), 72'(1));
        check("t3_first_p00", 72'(model_win(1, 1, 1)[71:64]), 72'(8'h80));

        // Frame start re-asserted at pixel (2,1)
        n_win  = 0;
        n_done = 0;
        run_frame(0, 1'b1, 1'b0, 9);
        run_frame(0, 1'b1, 1'b0, W * H);
        check("t4_windows", 72'(n_win), 72'(4));
        check("t4_done", 72'(n_done), 72'(1));

        // Two back-to-back frames
        n_win  = 0;
        n_done = 0;
        run_frame(0, 1'b1, 1'b0, W * H);
        run_frame(1, 1'b1, 1'b0, W * H);
        check("t5_windows", 72'(n_win), 72'(8));
        check("t5_done", 72'(n_done), 72'(2));

        step(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("pending_windows", 72'(exp_q.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
